fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined ARM core, directly upstream of the decode stage. It owns the program counter, issues requests on a wait-state-capable instruction-memory port, and holds the fetch/decode pipeline register. That register supplies the decoder's `Instruction` and `PCPlus8D` inputs. It redirects on taken branches (execute) and on writes to R15 (writeback), and honours stall/flush requests from the hazard unit.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_stage_if.sv | 28 ++
 rtl/fetch_decode_reg.sv | 55 +++++
 rtl/fetch_stage.sv | 148 ++++++++++++++
 tb/tb_fetch_stage.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   fetch_state_t : fetch FSM states (FETCH issue/wait, HOLD skid full, DRAIN discard)
//   NOP_INSTR     : bubble encoding (MOV R0,R0)
//   PC_STEP       : sequential PC increment
//   PC_PLUS8      : ARM pipeline PC offset reported with each instruction
//   word_align    : clears the byte-offset bits of an address
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] PC_PLUS8  = 32'd8;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port of the fetch stage.
//   ImemReq   : request valid (fetch side)
//   ImemAddr  : word address, held while ImemReq=1 and ImemReady=0
//   ImemReady : memory accepts the request; ImemRdata valid in the same cycle
//   ImemRdata : fetched instruction word
// master = fetch stage, slave = instruction memory.
interface fetch_stage_if;

    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemReady;
    logic [31:0] ImemRdata;

    modport master (
        output ImemReq,
        output ImemAddr,
        input  ImemReady,
        input  ImemRdata
    );

    modport slave (
        input  ImemReq,
        input  ImemAddr,
        output ImemReady,
        output ImemRdata
    );

endinterface

// File: rtl/fetch_decode_reg.sv
// Fetch/decode pipeline register.
//   clk, rst      : clock, synchronous active-high reset (loads a bubble)
//   stall         : hold current contents
//   flush         : load a bubble (beats stall)
//   load          : capture instr_in / pc_plus8_in as a valid instruction
//   instr_in      : instruction word to capture
//   pc_plus8_in   : PC of that instruction plus 8
//   instr, pc_plus8, valid : registered outputs to decode
// Without load the register takes a bubble, so wait states and discarded
// responses never leave a stale instruction marked valid.
module fetch_decode_reg
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        load,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_plus8_in,
    output logic [31:0] instr,
    output logic [31:0] pc_plus8,
    output logic        valid
);

    logic [31:0] instr_r;
    logic [31:0] pc_plus8_r;
    logic        valid_r;

    // F/D update: reset, flush, stall, load, bubble in falling priority
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            instr_r    <= NOP_INSTR;
            pc_plus8_r <= 32'h0000_0000;
            valid_r    <= 1'b0;
        end else if (stall) begin
            instr_r    <= instr_r;
            pc_plus8_r <= pc_plus8_r;
            valid_r    <= valid_r;
        end else if (load) begin
            instr_r    <= instr_in;
            pc_plus8_r <= pc_plus8_in;
            valid_r    <= 1'b1;
        end else begin
            instr_r    <= NOP_INSTR;
            pc_plus8_r <= 32'h0000_0000;
            valid_r    <= 1'b0;
        end
    end

    assign instr    = instr_r;
    assign pc_plus8 = pc_plus8_r;
    assign valid    = valid_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, instruction-memory requests, skid buffer for
// responses that arrive while decode is stalled, redirect handling and the
// F/D pipeline register.
//   Clk, Rst        : clock, synchronous active-high reset
//   StallF, FlushD  : hazard-unit stall / bubble requests
//   BranchTakenE/BranchTargetE : execute-stage redirect
//   PCSrcW/ResultW  : writeback R15 redirect (wins over execute)
//   imem            : instruction-memory port (master side)
//   InstrD, PCPlus8D, ValidD : F/D register outputs to decode
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 StallF,
    input  logic                 FlushD,
    input  logic                 BranchTakenE,
    input  logic [31:0]          BranchTargetE,
    input  logic                 PCSrcW,
    input  logic [31:0]          ResultW,
    fetch_stage_if.master        imem,
    output logic [31:0]          InstrD,
    output logic [31:0]          PCPlus8D,
    output logic                 ValidD
);

    fetch_state_t state_r, state_next_s;
    logic [31:0]  pc_r, pc_next_s;
    logic [31:0]  skid_r, skid_next_s;
    logic [31:0]  target_r, target_next_s;
    logic         redirect_s;
    logic [31:0]  redirect_target_s;
    logic         load_s;
    logic [31:0]  load_instr_s;
    logic [31:0]  pc_plus8_s;

    // Redirect source select: writeback R15 write overrides an execute branch
    always_comb begin
        redirect_s = PCSrcW | BranchTakenE;
        if (PCSrcW) begin
            redirect_target_s = word_align(ResultW);
        end else begin
            redirect_target_s = word_align(BranchTargetE);
        end
    end

    // Next-state, next-PC, skid/target capture and F/D load decision
    always_comb begin
        state_next_s  = state_r;
        pc_next_s     = pc_r;
        skid_next_s   = skid_r;
        target_next_s = target_r;
        load_s        = 1'b0;
        load_instr_s  = imem.ImemRdata;
        case (state_r)
            FETCH: begin
                if (redirect_s) begin
                    // A response accepted now belongs to the wrong path
                    if (imem.ImemReady) begin
                        pc_next_s = redirect_target_s;
                    end else begin
                        // Request still outstanding: keep address, finish it later
                        target_next_s = redirect_target_s;
                        state_next_s  = DRAIN;
                    end
                end else if (imem.ImemReady) begin
                    if (StallF) begin
                        skid_next_s  = imem.ImemRdata;
                        state_next_s = HOLD;
                    end else begin
                        load_s    = 1'b1;
                        pc_next_s = pc_r + PC_STEP;
                    end
                end else begin
                    state_next_s = FETCH;
                end
            end
            HOLD: begin
                if (redirect_s) begin
                    pc_next_s    = redirect_target_s;
                    state_next_s = FETCH;
                end else if (!StallF) begin
                    load_s       = 1'b1;
                    load_instr_s = skid_r;
                    pc_next_s    = pc_r + PC_STEP;
                    state_next_s = FETCH;
                end else begin
                    state_next_s = HOLD;
                end
            end
            DRAIN: begin
                if (imem.ImemReady) begin
                    if (redirect_s) begin
                        pc_next_s = redirect_target_s;
                    end else begin
                        pc_next_s = target_r;
                    end
                    state_next_s = FETCH;
                end else if (redirect_s) begin
                    target_next_s = redirect_target_s;
                end else begin
                    target_next_s = target_r;
                end
            end
            default: begin
                state_next_s = FETCH;
            end
        endcase
    end

    // State, PC, skid and latched-target registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r  <= FETCH;
            pc_r     <= word_align(RESET_VECTOR);
            skid_r   <= NOP_INSTR;
            target_r <= 32'h0000_0000;
        end else begin
            state_r  <= state_next_s;
            pc_r     <= pc_next_s;
            skid_r   <= skid_next_s;
            target_r <= target_next_s;
        end
    end

    assign pc_plus8_s = pc_r + PC_PLUS8;

    // PC is only changed once its request completes, so it is also the
    // outstanding address in DRAIN and stays stable across wait states.
    assign imem.ImemReq  = (state_r != HOLD) && !Rst;
    assign imem.ImemAddr = word_align(pc_r);

    fetch_decode_reg u_fd_reg (
        .clk         (Clk),
        .rst         (Rst),
        .stall       (StallF),
        .flush       (FlushD),
        .load        (load_s),
        .instr_in    (load_instr_s),
        .pc_plus8_in (pc_plus8_s),
        .instr       (InstrD),
        .pc_plus8    (PCPlus8D),
        .valid       (ValidD)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand-written
// corner sequences, then randomized stimulus against a transaction-level model.
module tb_fetch_stage;
    import fetch_pkg::*;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic        bt;
        logic [31:0] btgt;
        logic        pw;
        logic [31:0] rw;
        logic        ready;
    } in_t;

    typedef struct {
        in_t         i;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc8;
        logic        chk_pc8;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_f;
    logic        flush_d;
    logic        branch_taken_e;
    logic [31:0] branch_target_e;
    logic        pc_src_w;
    logic [31:0] result_w;
    logic [31:0] instr_d;
    logic [31:0] pc_plus8_d;
    logic        valid_d;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_stage_if bus();

    always #5 clk = ~clk;

    // Memory: word i holds 0xE2800000 + i
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hE280_0000 + (a >> 2);
    endfunction

    assign bus.ImemRdata = mem_word(bus.ImemAddr);

    fetch_stage dut (
        .Clk           (clk),
        .Rst           (rst),
        .StallF        (stall_f),
        .FlushD        (flush_d),
        .BranchTakenE  (branch_taken_e),
        .BranchTargetE (branch_target_e),
        .PCSrcW        (pc_src_w),
        .ResultW       (result_w),
        .imem          (bus),
        .InstrD        (instr_d),
        .PCPlus8D      (pc_plus8_d),
        .ValidD        (valid_d)
    );

    // ---------------- reference model (transaction level) ----------------
    logic [31:0] m_pc;
    bit          m_holding;
    bit          m_draining;
    logic [31:0] m_tgt;
    logic [31:0] m_skid[$];
    logic [31:0] m_fd_instr;
    logic [31:0] m_fd_pc8;
    logic        m_fd_valid;

    task automatic model_reset();
        m_pc       = 32'h0000_0000;
        m_holding  = 1'b0;
        m_draining = 1'b0;
        m_tgt      = 32'h0000_0000;
        m_skid.delete();
        m_fd_instr = NOP_INSTR;
        m_fd_pc8   = 32'h0000_0000;
        m_fd_valid = 1'b0;
    endtask

    task automatic model_step(input in_t i);
        logic        redir;
        logic [31:0] tgt;
        logic [31:0] data;
        logic [31:0] old_pc;
        bit          took;
        if (i.rst) begin
            model_reset();
            return;
        end
        redir  = i.pw | i.bt;
        tgt    = i.pw ? i.rw : i.btgt;
        tgt    = tgt & 32'hFFFF_FFFC;
        old_pc = m_pc;
        took   = 1'b0;
        data   = 32'h0000_0000;
        if (m_holding) begin
            if (redir) begin
                m_pc = tgt;
                m_holding = 1'b0;
                m_skid.delete();
            end else if (!i.stall) begin
                took = 1'b1;
                data = m_skid.pop_front();
                m_pc = m_pc + 32'd4;
                m_holding = 1'b0;
            end
        end else if (m_draining) begin
            if (redir) m_tgt = tgt;
            if (i.ready) begin
                m_pc = m_tgt;
                m_draining = 1'b0;
            end
        end else begin
            if (redir) begin
                if (i.ready) m_pc = tgt;
                else begin
                    m_draining = 1'b1;
                    m_tgt = tgt;
                end
            end else if (i.ready) begin
                if (i.stall) begin
                    m_skid.push_back(mem_word(m_pc));
                    m_holding = 1'b1;
                end else begin
                    took = 1'b1;
                    data = mem_word(m_pc);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        if (i.flush || (!i.stall && !took)) begin
            m_fd_instr = NOP_INSTR;
            m_fd_pc8   = 32'h0000_0000;
            m_fd_valid = 1'b0;
        end else if (!i.stall) begin
            m_fd_instr = data;
            m_fd_pc8   = old_pc + 32'd8;
            m_fd_valid = 1'b1;
        end
    endtask

    // ---------------- helpers ----------------
    function automatic vec_t mk(input logic r, input logic st, input logic fl,
                                input logic bt, input logic [31:0] btgt,
                                input logic pw, input logic [31:0] rw,
                                input logic rdy, input logic req,
                                input logic [31:0] addr, input logic v,
                                input logic [31:0] ins, input logic [31:0] p8);
        vec_t x;
        x.i.rst = r; x.i.stall = st; x.i.flush = fl; x.i.bt = bt;
        x.i.btgt = btgt; x.i.pw = pw; x.i.rw = rw; x.i.ready = rdy;
        x.req = req; x.addr = addr; x.valid = v; x.instr = ins; x.pc8 = p8;
        x.chk_pc8 = v;
        return x;
    endfunction

    task automatic drive(input in_t i);
        rst             = i.rst;
        stall_f         = i.stall;
        flush_d         = i.flush;
        branch_taken_e  = i.bt;
        branch_target_e = i.btgt;
        pc_src_w        = i.pw;
        result_w        = i.rw;
        bus.ImemReady   = i.ready;
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: actual %h required %h", nm, idx, act, exp);
        end
    endtask

    // Apply one cycle of inputs, compare outputs mid-cycle, advance past the edge
    task automatic run_vec(input vec_t v, input int idx);
        drive(v.i);
        @(negedge clk);
        chk("req",   idx, {31'd0, bus.ImemReq}, {31'd0, v.req});
        chk("addr",  idx, bus.ImemAddr, v.addr);
        chk("valid", idx, {31'd0, valid_d}, {31'd0, v.valid});
        chk("instr", idx, instr_d, v.instr);
        if (v.chk_pc8) chk("pc8", idx, pc_plus8_d, v.pc8);
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] N = NOP_INSTR;
    vec_t tbl[32];

    initial begin
        in_t ri;
        vec_t rv;

        //        rst st fl bt btgt          pw rw            rdy | req addr           v  instr          pc8
        tbl[0]  = mk(1, 0, 0, 0, 32'h0,        0, 32'h0,        1,   0, 32'h0000_0000, 0, N,             32'h0);
        tbl[0].chk_pc8 = 1'b1;
        tbl[1]  = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        1,   1, 32'h0000_0000, 0, N,             32'h0);
        tbl[2]  = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        1,   1, 32'h0000_0004, 1, 32'hE280_0000, 32'h08);
        tbl[3]  = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        1,   1, 32'h0000_0008, 1, 32'hE280_0001, 32'h0C);
        tbl[4]  = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        1,   1, 32'h0000_000C, 1, 32'hE280_0002, 32'h10);
        tbl[5]  = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        0,   1, 32'h0000_0010, 1, 32'hE280_0003, 32'h14);
        tbl[6]  = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        0,   1, 32'h0000_0010, 0, N,             32'h0);
        tbl[7]  = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        0,   1, 32'h0000_0010, 0, N,             32'h0);
        tbl[8]  = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        1,   1, 32'h0000_0010, 0, N,             32'h0);
        tbl[9]  = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        1,   1, 32'h0000_0014, 1, 32'hE280_0004, 32'h18);
        tbl[10] = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        1,   1, 32'h0000_0018, 1, 32'hE280_0005, 32'h1C);
        tbl[11] = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        1,   1, 32'h0000_001C, 1, 32'hE280_0006, 32'h20);
        tbl[12] = mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        1,   1, 32'h0000_0020, 1, 32'hE280_0007, 32'h24);
        tbl[13] = mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        1,   0, 32'h0000_0020, 1, 32'hE280_0007, 32'h24);
        tbl[14] = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        1,   0, 32'h0000_0020, 1, 32'hE280_0007, 32'h24);
        tbl[15] = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        1,   1, 32'h0000_0024, 1, 32'hE280_0008, 32'h28);
        tbl[16] = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        1,   1, 32'h0000_0028, 1, 32'hE280_0009, 32'h2C);
        tbl[17] = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        1,   1, 32'h0000_002C, 1, 32'hE280_000A, 32'h30);
        tbl[18] = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        1,   1, 32'h0000_0030, 1, 32'hE280_000B, 32'h34);
        tbl[19] = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        1,   1, 32'h0000_0034, 1, 32'hE280_000C, 32'h38);
        tbl[20] = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        1,   1, 32'h0000_0038, 1, 32'hE280_000D, 32'h3C);
        tbl[21] = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        1,   1, 32'h0000_003C, 1, 32'hE280_000E, 32'h40);
        tbl[22] = mk(0, 0, 0, 1, 32'h100,      0, 32'h0,        0,   1, 32'h0000_0040, 1, 32'hE280_000F, 32'h44);
        tbl[23] = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        0,   1, 32'h0000_0040, 0, N,             32'h0);
        tbl[24] = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        1,   1, 32'h0000_0040, 0, N,             32'h0);
        tbl[25] = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        1,   1, 32'h0000_0100, 0, N,             32'h0);
        tbl[26] = mk(0, 0, 1, 1, 32'h300,      1, 32'h200,      1,   1, 32'h0000_0104, 1, 32'hE280_0040, 32'h108);
        tbl[27] = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        1,   1, 32'h0000_0200, 0, N,             32'h0);
        tbl[28] = mk(0, 0, 0, 0, 32'h0,        1, 32'hFFFF_FFFE,1,   1, 32'h0000_0204, 1, 32'hE280_0080, 32'h208);
        tbl[29] = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        1,   1, 32'hFFFF_FFFC, 0, N,             32'h0);
        tbl[30] = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        1,   1, 32'h0000_0000, 1, 32'h227F_FFFF, 32'h04);
        tbl[31] = mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        1,   1, 32'h0000_0004, 1, 32'hE280_0000, 32'h08);

        drive(tbl[0].i);
        repeat (3) @(posedge clk);
        #1;

        for (int k = 0; k < 32; k++) run_vec(tbl[k], k);

        // DRAIN: later PCSrcW overrides latched branch target, then completes
        run_vec(mk(0, 0, 0, 1, 32'h500, 0, 32'h0,   0, 1, 32'h0000_0008, 1, 32'hE280_0001, 32'h0C), 100);
        run_vec(mk(0, 0, 0, 1, 32'h700, 1, 32'h600, 0, 1, 32'h0000_0008, 0, N, 32'h0), 101);
        run_vec(mk(0, 0, 0, 0, 32'h0,   0, 32'h0,   1, 1, 32'h0000_0008, 0, N, 32'h0), 102);
        // Enter DRAIN again, then reset aborts it
        run_vec(mk(0, 0, 0, 1, 32'h800, 0, 32'h0,   0, 1, 32'h0000_0600, 0, N, 32'h0), 103);
        run_vec(mk(1, 0, 0, 0, 32'h0,   0, 32'h0,   1, 0, 32'h0000_0600, 0, N, 32'h0), 104);
        run_vec(mk(0, 0, 0, 0, 32'h0,   0, 32'h0,   1, 1, 32'h0000_0000, 0, N, 32'h0), 105);
        // Stall into HOLD, redirect while stalled wins, F/D keeps its contents
        run_vec(mk(0, 1, 0, 0, 32'h0,   0, 32'h0,   1, 1, 32'h0000_0004, 1, 32'hE280_0000, 32'h08), 106);
        run_vec(mk(0, 1, 0, 1, 32'h900, 0, 32'h0,   1, 0, 32'h0000_0004, 1, 32'hE280_0000, 32'h08), 107);
        run_vec(mk(0, 0, 0, 0, 32'h0,   0, 32'h0,   1, 1, 32'h0000_0900, 1, 32'hE280_0000, 32'h08), 108);
        run_vec(mk(0, 0, 0, 0, 32'h0,   0, 32'h0,   1, 1, 32'h0000_0904, 1, 32'hE280_0240, 32'h908), 109);

        // Randomized phase: resynchronise with one reset cycle
        ri = '{rst: 1'b1, stall: 1'b0, flush: 1'b0, bt: 1'b0, btgt: 32'h0,
               pw: 1'b0, rw: 32'h0, ready: 1'b1};
        drive(ri);
        @(posedge clk);
        #1;
        model_reset();
        for (int n = 0; n < 600; n++) begin
            ri.rst   = ($urandom_range(0, 49) == 0);
            ri.stall = ($urandom_range(0, 3) == 0);
            ri.flush = ($urandom_range(0, 7) == 0);
            ri.bt    = ($urandom_range(0, 7) == 0);
            ri.btgt  = $urandom;
            ri.pw    = ($urandom_range(0, 15) == 0);
            ri.rw    = $urandom;
            ri.ready = ($urandom_range(0, 2) != 0);
            rv.i       = ri;
            rv.req     = !ri.rst && !m_holding;
            rv.addr    = m_pc;
            rv.valid   = m_fd_valid;
            rv.instr   = m_fd_instr;
            rv.pc8     = m_fd_pc8;
            rv.chk_pc8 = m_fd_valid;
            run_vec(rv, 1000 + n);
            model_step(ri);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
